// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the FIFO queue and the LIFO stack blocks.
//   ptr_width(depth) : bits needed to index 'depth' entries (at least 1)
//   cnt_width(depth) : bits needed to hold an occupancy of 0..depth
//   DEF_WL/DEF_DEPTH : default word width and storage depth
package fifo_pkg;

  localparam int DEF_WL    = 4;
  localparam int DEF_DEPTH = 4;

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/queue_fifo_if.sv
// queue_fifo_if: request/status bundle between a producer/consumer pair and
// the queue.
//   master : drives wReq/din/rReq, observes data and status
//   slave  : the queue itself
// Handshake: wReq and rReq are single-cycle requests sampled on the rising
// CLK edge; there is no ready/stall. A request the queue cannot honour is
// dropped and reported one cycle later by ERROR plus the sticky OVF/UDF bit.
// A popped word appears on dout with dvalid high for exactly one cycle.
interface queue_fifo_if
  import fifo_pkg::*;
#(
  parameter int WL    = DEF_WL,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = cnt_width(DEPTH);

  logic          wReq;
  logic [WL-1:0] din;
  logic          rReq;
  logic [WL-1:0] dout;
  logic          dvalid;
  logic          FULL;
  logic          EMPTY;
  logic          AFULL;
  logic          AEMPTY;
  logic [CW-1:0] count;
  logic          ERROR;
  logic          OVF;
  logic          UDF;

  modport master (
    output wReq, din, rReq,
    input  dout, dvalid, FULL, EMPTY, AFULL, AEMPTY, count, ERROR, OVF, UDF
  );

  modport slave (
    input  wReq, din, rReq,
    output dout, dvalid, FULL, EMPTY, AFULL, AEMPTY, count, ERROR, OVF, UDF
  );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer for circular storage.
//   CLK : clock, rising edge
//   RST : synchronous active-low reset, clears ptr to 0
//   inc : advance pointer by one this cycle
//   ptr : current pointer, wraps from DEPTH-1 to 0 (DEPTH need not be 2^n)
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        inc,
  output logic [ptr_width(DEPTH)-1:0] ptr
);
  localparam int PW = ptr_width(DEPTH);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/queue_fifo.sv
// queue_fifo: synchronous FIFO queue with occupancy count, almost flags and
// sticky overflow/underflow status. Drop-in alternative to the LIFO stack.
//   CLK    : clock, rising edge
//   RST    : synchronous active-low reset (priority over all requests)
//   bus    : queue_fifo_if.slave
//            wReq/din push at the tail, rReq pops the head into dout (1-cycle
//            latency, dvalid pulse); FULL/EMPTY/AFULL/AEMPTY/count derive from
//            the registered occupancy; ERROR pulses the cycle after a
//            rejected request; OVF/UDF are sticky until reset.
module queue_fifo
  import fifo_pkg::*;
#(
  parameter int WL     = DEF_WL,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic        CLK,
  input  logic        RST,
  queue_fifo_if.slave bus
);
  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WL-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          empty;
  logic          rd_ok;
  logic          wr_ok;
  logic          wr_rej;
  logic          rd_rej;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // A read frees a slot in the same cycle, so a full queue still takes a
  // write alongside a read. An empty queue never forwards din to dout.
  assign rd_ok  = bus.rReq & ~empty;
  assign wr_ok  = bus.wReq & (~full | rd_ok);
  assign wr_rej = bus.wReq & ~wr_ok;
  assign rd_rej = bus.rReq & ~rd_ok;

  assign bus.FULL   = full;
  assign bus.EMPTY  = empty;
  assign bus.AFULL  = (cnt_q >= CW'(AF_LVL));
  assign bus.AEMPTY = (cnt_q <= CW'(AE_LVL));
  assign bus.count  = cnt_q;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .CLK (CLK),
    .RST (RST),
    .inc (wr_ok),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .CLK (CLK),
    .RST (RST),
    .inc (rd_ok),
    .ptr (rd_ptr)
  );

  // Storage is deliberately not cleared by reset; writes are blocked during it.
  always_ff @(posedge CLK) begin
    if (RST && wr_ok) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q      <= '0;
      bus.dout   <= '0;
      bus.dvalid <= 1'b0;
      bus.ERROR  <= 1'b0;
      bus.OVF    <= 1'b0;
      bus.UDF    <= 1'b0;
    end else begin
      bus.dvalid <= rd_ok;
      if (rd_ok) begin
        bus.dout <= mem[rd_ptr];
      end
      bus.ERROR <= wr_rej | rd_rej;
      if (wr_rej) begin
        bus.OVF <= 1'b1;
      end
      if (rd_rej) begin
        bus.UDF <= 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_fifo.sv
// tb_queue_fifo: self-checking bench for queue_fifo (WL=4, DEPTH=4).
// Reference model is a plain queue of words plus expected flag values.
module tb_queue_fifo;
  import fifo_pkg::*;

  localparam int WL    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = cnt_width(DEPTH);

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  queue_fifo_if #(.WL(WL), .DEPTH(DEPTH)) bus ();

  queue_fifo #(
    .WL     (WL),
    .DEPTH  (DEPTH),
    .AF_LVL (DEPTH - 1),
    .AE_LVL (1)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  logic [WL-1:0] exp_q[$];
  logic [WL-1:0] exp_dout   = '0;
  logic          exp_dvalid = 1'b0;
  logic          exp_err    = 1'b0;
  logic          exp_ovf    = 1'b0;
  logic          exp_udf    = 1'b0;

  // ---------------- driver ----------------
  // Applies one cycle of stimulus, advances the model, returns at edge+1.
  task automatic cycle(input logic w, input logic [WL-1:0] d, input logic r,
                       input logic rst_n);
    bit rd_acc;
    bit wr_acc;
    RST      = rst_n;
    bus.wReq = w;
    bus.din  = d;
    bus.rReq = r;
    if (!rst_n) begin
      exp_q.delete();
      exp_dout   = '0;
      exp_dvalid = 1'b0;
      exp_err    = 1'b0;
      exp_ovf    = 1'b0;
      exp_udf    = 1'b0;
    end else begin
      rd_acc = r && (exp_q.size() > 0);
      wr_acc = w && ((exp_q.size() < DEPTH) || rd_acc);
      exp_dvalid = rd_acc;
      if (rd_acc) exp_dout = exp_q.pop_front();
      if (wr_acc) exp_q.push_back(d);
      exp_err = (w && !wr_acc) || (r && !rd_acc);
      if (w && !wr_acc) exp_ovf = 1'b1;
      if (r && !rd_acc) exp_udf = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle(1'b1, 4'hA, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (3) idle();
    checks++; if (bus.EMPTY !== 1'b1) $display("FAIL reset_empty act=%b exp=1", bus.EMPTY); else passes++;
    checks++; if (bus.AEMPTY !== 1'b1) $display("FAIL reset_aempty act=%b exp=1", bus.AEMPTY); else passes++;
    checks++; if (bus.FULL !== 1'b0) $display("FAIL reset_full act=%b exp=0", bus.FULL); else passes++;
    checks++; if (bus.AFULL !== 1'b0) $display("FAIL reset_afull act=%b exp=0", bus.AFULL); else passes++;
    checks++; if (bus.count !== CW'(0)) $display("FAIL reset_count act=%0d exp=0", bus.count); else passes++;
    checks++; if (bus.dout !== 4'd0) $display("FAIL reset_dout act=%0d exp=0", bus.dout); else passes++;
    checks++; if (bus.dvalid !== 1'b0) $display("FAIL reset_dvalid act=%b exp=0", bus.dvalid); else passes++;
    checks++; if (bus.ERROR !== 1'b0) $display("FAIL reset_error act=%b exp=0", bus.ERROR); else passes++;
    checks++; if (bus.OVF !== 1'b0) $display("FAIL reset_ovf act=%b exp=0", bus.OVF); else passes++;
    checks++; if (bus.UDF !== 1'b0) $display("FAIL reset_udf act=%b exp=0", bus.UDF); else passes++;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, WL'(i), 1'b0, 1'b1);
      if (i == 3) begin
        checks++; if (bus.AFULL !== 1'b1) $display("FAIL fill_afull3 act=%b exp=1", bus.AFULL); else passes++;
        checks++; if (bus.FULL !== 1'b0) $display("FAIL fill_full3 act=%b exp=0", bus.FULL); else passes++;
      end
    end
    checks++; if (bus.FULL !== 1'b1) $display("FAIL fill_full act=%b exp=1", bus.FULL); else passes++;
    checks++; if (bus.count !== CW'(4)) $display("FAIL fill_count act=%0d exp=4", bus.count); else passes++;
    checks++; if (bus.AEMPTY !== 1'b0) $display("FAIL fill_aempty act=%b exp=0", bus.AEMPTY); else passes++;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      checks++; if (bus.dout !== WL'(i)) $display("FAIL drain_dout act=%0d exp=%0d", bus.dout, i); else passes++;
      checks++; if (bus.dvalid !== 1'b1) $display("FAIL drain_dvalid act=%b exp=1", bus.dvalid); else passes++;
    end
    checks++; if (bus.EMPTY !== 1'b1) $display("FAIL drain_empty act=%b exp=1", bus.EMPTY); else passes++;
    idle();
    checks++; if (bus.dvalid !== 1'b0) $display("FAIL drain_idle_dvalid act=%b exp=0", bus.dvalid); else passes++;
    checks++; if (bus.dout !== 4'd4) $display("FAIL drain_idle_dout act=%0d exp=4", bus.dout); else passes++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) cycle(1'b1, WL'(i), 1'b0, 1'b1);
    cycle(1'b1, 4'd9, 1'b0, 1'b1);
    checks++; if (bus.ERROR !== 1'b1) $display("FAIL ovf_error act=%b exp=1", bus.ERROR); else passes++;
    checks++; if (bus.OVF !== 1'b1) $display("FAIL ovf_flag act=%b exp=1", bus.OVF); else passes++;
    checks++; if (bus.count !== CW'(4)) $display("FAIL ovf_count act=%0d exp=4", bus.count); else passes++;
    idle();
    checks++; if (bus.ERROR !== 1'b0) $display("FAIL ovf_error_clear act=%b exp=0", bus.ERROR); else passes++;
    checks++; if (bus.OVF !== 1'b1) $display("FAIL ovf_sticky act=%b exp=1", bus.OVF); else passes++;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      checks++; if (bus.dout !== WL'(i)) $display("FAIL ovf_read act=%0d exp=%0d", bus.dout, i); else passes++;
    end
    checks++; if (bus.EMPTY !== 1'b1) $display("FAIL ovf_empty act=%b exp=1", bus.EMPTY); else passes++;
  endtask

  task automatic test_underflow();
    cycle(1'b0, '0, 1'b1, 1'b1);
    checks++; if (bus.ERROR !== 1'b1) $display("FAIL udf_error act=%b exp=1", bus.ERROR); else passes++;
    checks++; if (bus.UDF !== 1'b1) $display("FAIL udf_flag act=%b exp=1", bus.UDF); else passes++;
    checks++; if (bus.dvalid !== 1'b0) $display("FAIL udf_dvalid act=%b exp=0", bus.dvalid); else passes++;
    checks++; if (bus.dout !== 4'd4) $display("FAIL udf_dout act=%0d exp=4", bus.dout); else passes++;
    checks++; if (bus.count !== CW'(0)) $display("FAIL udf_count act=%0d exp=0", bus.count); else passes++;
    idle();
    checks++; if (bus.ERROR !== 1'b0) $display("FAIL udf_error_clear act=%b exp=0", bus.ERROR); else passes++;
  endtask

  task automatic test_simul_full();
    for (int i = 1; i <= 4; i++) cycle(1'b1, WL'(i), 1'b0, 1'b1);
    cycle(1'b1, 4'd7, 1'b1, 1'b1);
    checks++; if (bus.dout !== 4'd1) $display("FAIL simf_dout act=%0d exp=1", bus.dout); else passes++;
    checks++; if (bus.count !== CW'(4)) $display("FAIL simf_count act=%0d exp=4", bus.count); else passes++;
    checks++; if (bus.ERROR !== 1'b0) $display("FAIL simf_error act=%b exp=0", bus.ERROR); else passes++;
    for (int i = 0; i < 4; i++) begin
      logic [WL-1:0] want;
      want = (i == 3) ? 4'd7 : WL'(i + 2);
      cycle(1'b0, '0, 1'b1, 1'b1);
      checks++; if (bus.dout !== want) $display("FAIL simf_read act=%0d exp=%0d", bus.dout, want); else passes++;
    end
  endtask

  task automatic test_simul_empty();
    cycle(1'b1, 4'd5, 1'b1, 1'b1);
    checks++; if (bus.count !== CW'(1)) $display("FAIL sime_count act=%0d exp=1", bus.count); else passes++;
    checks++; if (bus.ERROR !== 1'b1) $display("FAIL sime_error act=%b exp=1", bus.ERROR); else passes++;
    checks++; if (bus.UDF !== 1'b1) $display("FAIL sime_udf act=%b exp=1", bus.UDF); else passes++;
    checks++; if (bus.dvalid !== 1'b0) $display("FAIL sime_dvalid act=%b exp=0", bus.dvalid); else passes++;
    cycle(1'b0, '0, 1'b1, 1'b1);
    checks++; if (bus.dout !== 4'd5) $display("FAIL sime_read act=%0d exp=5", bus.dout); else passes++;
    checks++; if (bus.dvalid !== 1'b1) $display("FAIL sime_dvalid2 act=%b exp=1", bus.dvalid); else passes++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      logic [WL-1:0] v;
      v = WL'($urandom_range(0, 15));
      cycle(1'b1, v, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b1);
      checks++; if (bus.dout !== v) $display("FAIL wrap_read act=%0d exp=%0d", bus.dout, v); else passes++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), WL'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'b1);
      checks++; if (bus.count !== CW'(exp_q.size())) $display("FAIL rnd_count act=%0d exp=%0d", bus.count, exp_q.size()); else passes++;
      checks++; if (bus.dvalid !== exp_dvalid) $display("FAIL rnd_dvalid act=%b exp=%b", bus.dvalid, exp_dvalid); else passes++;
      checks++; if (bus.dout !== exp_dout) $display("FAIL rnd_dout act=%0d exp=%0d", bus.dout, exp_dout); else passes++;
      checks++; if (bus.ERROR !== exp_err) $display("FAIL rnd_error act=%b exp=%b", bus.ERROR, exp_err); else passes++;
      checks++; if ({bus.OVF, bus.UDF} !== {exp_ovf, exp_udf}) $display("FAIL rnd_sticky act=%b%b exp=%b%b", bus.OVF, bus.UDF, exp_ovf, exp_udf); else passes++;
      checks++; if ({bus.FULL, bus.EMPTY, bus.AFULL, bus.AEMPTY} !==
                    {exp_q.size() == DEPTH, exp_q.size() == 0,
                     exp_q.size() >= DEPTH - 1, exp_q.size() <= 1})
        $display("FAIL rnd_flags act=%b%b%b%b size=%0d", bus.FULL, bus.EMPTY, bus.AFULL, bus.AEMPTY, exp_q.size());
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    // Make both sticky bits set and leave three words queued.
    for (int i = 0; i <= DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i <= DEPTH; i++) cycle(1'b1, WL'(i + 1), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    checks++; if (bus.count !== CW'(3)) $display("FAIL mrst_pre_count act=%0d exp=3", bus.count); else passes++;
    checks++; if ({bus.OVF, bus.UDF} !== 2'b11) $display("FAIL mrst_pre_sticky act=%b%b exp=11", bus.OVF, bus.UDF); else passes++;
    cycle(1'b1, 4'd3, 1'b1, 1'b0);
    checks++; if (bus.count !== CW'(0)) $display("FAIL mrst_count act=%0d exp=0", bus.count); else passes++;
    checks++; if (bus.EMPTY !== 1'b1) $display("FAIL mrst_empty act=%b exp=1", bus.EMPTY); else passes++;
    checks++; if (bus.OVF !== 1'b0) $display("FAIL mrst_ovf act=%b exp=0", bus.OVF); else passes++;
    checks++; if (bus.UDF !== 1'b0) $display("FAIL mrst_udf act=%b exp=0", bus.UDF); else passes++;
    checks++; if (bus.dout !== 4'd0) $display("FAIL mrst_dout act=%0d exp=0", bus.dout); else passes++;
    cycle(1'b1, 4'd6, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    checks++; if (bus.dout !== 4'd6) $display("FAIL mrst_after act=%0d exp=6", bus.dout); else passes++;
    checks++; if (bus.EMPTY !== 1'b1) $display("FAIL mrst_after_empty act=%b exp=1", bus.EMPTY); else passes++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.wReq = 1'b0;
    bus.din  = '0;
    bus.rReq = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
